// File: rtl/calc_disp_pkg.sv
// Shared types and active-low segment codes for the calculator entry/display path.
// Segment bit order is dp,g,f,e,d,c,b,a; a 0 lights the segment.
package calc_disp_pkg;

  typedef enum logic [1:0] {
    S_A0   = 2'd0,
    S_OP   = 2'd1,
    S_A1   = 2'd2,
    S_SHOW = 2'd3
  } state_e;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_MINUS = 8'hBF;
  localparam logic [7:0] SEG_PLUS  = 8'h8F;
  localparam logic [7:0] SEG_EQ    = 8'hB7;
  localparam logic [7:0] SEG_ONE   = 8'hF9;

endpackage

// File: rtl/calc_entry_controller_key_edge.sv
// Registered rising-edge detector for one debounced key.
// press is high for exactly one cycle per low-to-high transition of key.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  logic key_q;
  logic key_d;

  always_comb begin
    key_d = key;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_d;
    end
  end

  assign press = key & ~key_q;

endmodule

// File: rtl/calc_entry_controller.sv
// Sequences A0 / operator / A1 entry from the switches and latches the 4-bit result
// plus the segment codes for the operator, '=' and carry/sign digits.
module calc_entry_controller
  import calc_disp_pkg::*;
#(
  parameter int BLINK_CYCLES = 25000000,
  parameter bit SUB_NEG_MAG  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn_next,
  input  logic       btn_op,
  input  logic       btn_clr,
  output logic [3:0] a0,
  output logic [3:0] a1,
  output logic [7:0] op,
  output logic [7:0] eq,
  output logic [7:0] prefix,
  output logic [3:0] result,
  output logic [3:0] state_led
);

  localparam int CW = $clog2(BLINK_CYCLES + 1);

  logic next_p, op_p, clr_p;

  key_edge u_next (.clk(clk), .rst(rst), .key(btn_next), .press(next_p));
  key_edge u_op   (.clk(clk), .rst(rst), .key(btn_op),   .press(op_p));
  key_edge u_clr  (.clk(clk), .rst(rst), .key(btn_clr),  .press(clr_p));

  state_e          state_q, state_d;
  op_e             op_sel_q, op_sel_d;
  logic [3:0]      a0_q, a0_d;
  logic [3:0]      a1_q, a1_d;
  logic [3:0]      result_q, result_d;
  logic [7:0]      prefix_q, prefix_d;
  logic [CW-1:0]   blink_cnt_q, blink_cnt_d;
  logic            blink_off_q, blink_off_d;

  // A1 is taken straight from sw on the advancing edge, so the result uses sw, not a1_q.
  logic [4:0] sum;
  logic [4:0] diff;
  logic [3:0] neg_mag;
  logic       neg;

  always_comb begin
    sum     = {1'b0, a0_q} + {1'b0, sw};
    diff    = {1'b0, a0_q} - {1'b0, sw};
    neg_mag = sw - a0_q;
    neg     = (a0_q < sw);
  end

  always_comb begin
    state_d     = state_q;
    op_sel_d    = op_sel_q;
    a0_d        = a0_q;
    a1_d        = a1_q;
    result_d    = result_q;
    prefix_d    = prefix_q;
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;

    if (clr_p) begin
      state_d     = S_A0;
      op_sel_d    = OP_ADD;
      a0_d        = 4'd0;
      a1_d        = 4'd0;
      result_d    = 4'd0;
      prefix_d    = SEG_BLANK;
      blink_cnt_d = '0;
      blink_off_d = 1'b0;
    end else begin
      unique case (state_q)
        S_A0: begin
          a0_d = sw;
          if (next_p) begin
            state_d     = S_OP;
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
          end
        end
        S_OP: begin
          if (blink_cnt_q == CW'(BLINK_CYCLES - 1)) begin
            blink_cnt_d = '0;
            blink_off_d = ~blink_off_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
          if (op_p) begin
            op_sel_d = (op_sel_q == OP_ADD) ? OP_SUB : OP_ADD;
          end
          if (next_p) begin
            state_d = S_A1;
            a1_d    = sw;
          end
        end
        S_A1: begin
          a1_d = sw;
          if (next_p) begin
            state_d = S_SHOW;
            if (op_sel_q == OP_ADD) begin
              result_d = sum[3:0];
              prefix_d = sum[4] ? SEG_ONE : SEG_BLANK;
            end else if (neg) begin
              result_d = SUB_NEG_MAG ? neg_mag : diff[3:0];
              prefix_d = SEG_MINUS;
            end else begin
              result_d = diff[3:0];
              prefix_d = SEG_BLANK;
            end
          end
        end
        S_SHOW: begin
          if (next_p) begin
            state_d     = S_A0;
            op_sel_d    = OP_ADD;
            a0_d        = 4'd0;
            a1_d        = 4'd0;
            result_d    = 4'd0;
            prefix_d    = SEG_BLANK;
            blink_cnt_d = '0;
            blink_off_d = 1'b0;
          end
        end
        default: state_d = S_A0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_A0;
      op_sel_q    <= OP_ADD;
      a0_q        <= 4'd0;
      a1_q        <= 4'd0;
      result_q    <= 4'd0;
      prefix_q    <= SEG_BLANK;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_sel_q    <= op_sel_d;
      a0_q        <= a0_d;
      a1_q        <= a1_d;
      result_q    <= result_d;
      prefix_q    <= prefix_d;
      blink_cnt_q <= blink_cnt_d;
      blink_off_q <= blink_off_d;
    end
  end

  logic [7:0] op_sym;

  always_comb begin
    op_sym    = (op_sel_q == OP_SUB) ? SEG_MINUS : SEG_PLUS;
    op        = SEG_BLANK;
    eq        = SEG_BLANK;
    state_led = 4'b0001;
    unique case (state_q)
      S_A0: begin
        op        = SEG_BLANK;
        state_led = 4'b0001;
      end
      S_OP: begin
        op        = blink_off_q ? SEG_BLANK : op_sym;
        state_led = 4'b0010;
      end
      S_A1: begin
        op        = op_sym;
        state_led = 4'b0100;
      end
      S_SHOW: begin
        op        = op_sym;
        eq        = SEG_EQ;
        state_led = 4'b1000;
      end
      default: begin
        op        = SEG_BLANK;
        state_led = 4'b0001;
      end
    endcase
  end

  assign a0     = a0_q;
  assign a1     = a1_q;
  assign prefix = prefix_q;
  assign result = result_q;

endmodule

// File: tb/tb_calc_entry_controller.sv
// Scoreboarded bench: a behavioural model predicts post-edge outputs for two DUTs
// (SUB_NEG_MAG = 1 and 0); a negedge monitor pops and compares each prediction.
module tb_calc_entry_controller;

  localparam int BLINK = 4;
  localparam logic [7:0] BLANK = 8'hFF;
  localparam logic [7:0] MINUS = 8'hBF;
  localparam logic [7:0] PLUS  = 8'h8F;
  localparam logic [7:0] EQS   = 8'hB7;
  localparam logic [7:0] ONE   = 8'hF9;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] sw;
  logic       btn_next, btn_op, btn_clr;

  logic [3:0] m_a0, m_a1, m_res, m_led;
  logic [7:0] m_op, m_eq, m_pre;
  logic [3:0] w_a0, w_a1, w_res, w_led;
  logic [7:0] w_op, w_eq, w_pre;

  always #5 clk = ~clk;

  calc_entry_controller #(.BLINK_CYCLES(BLINK), .SUB_NEG_MAG(1'b1)) dut_mag (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_op(btn_op), .btn_clr(btn_clr),
    .a0(m_a0), .a1(m_a1), .op(m_op), .eq(m_eq), .prefix(m_pre), .result(m_res), .state_led(m_led)
  );

  calc_entry_controller #(.BLINK_CYCLES(BLINK), .SUB_NEG_MAG(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .btn_op(btn_op), .btn_clr(btn_clr),
    .a0(w_a0), .a1(w_a1), .op(w_op), .eq(w_eq), .prefix(w_pre), .result(w_res), .state_led(w_led)
  );

  typedef struct {
    logic [3:0] a0, a1, res_mag, res_wrap, led;
    logic [7:0] op, eq, pre;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: phase 0=A0, 1=OP, 2=A1, 3=SHOW.
  int  phase;
  int  ma0, ma1, mres_mag, mres_wrap, op_cycles;
  bit  msub;
  logic [7:0] mpre;
  bit  pn, po, pc;

  task automatic model_clear();
    phase = 0; ma0 = 0; ma1 = 0; mres_mag = 0; mres_wrap = 0; msub = 0; mpre = BLANK;
  endtask

  task automatic model_edge(input bit r, input int s, input bit n, input bit o, input bit c);
    bit en, eo, ec;
    if (r) begin
      model_clear();
      pn = 0; po = 0; pc = 0;
      op_cycles = 0;
      return;
    end
    en = n && !pn; eo = o && !po; ec = c && !pc;
    pn = n; po = o; pc = c;
    if (ec) begin
      model_clear();
    end else if (phase == 0) begin
      ma0 = s;
      if (en) begin phase = 1; op_cycles = 0; end
    end else if (phase == 1) begin
      op_cycles++;
      if (eo) msub = !msub;
      if (en) begin phase = 2; ma1 = s; end
    end else if (phase == 2) begin
      ma1 = s;
      if (en) begin
        phase = 3;
        if (!msub) begin
          mres_mag = (ma0 + ma1) % 16; mres_wrap = mres_mag;
          mpre = (ma0 + ma1 > 15) ? ONE : BLANK;
        end else if (ma0 >= ma1) begin
          mres_mag = ma0 - ma1; mres_wrap = mres_mag; mpre = BLANK;
        end else begin
          mres_mag = ma1 - ma0; mres_wrap = ma0 - ma1 + 16; mpre = MINUS;
        end
      end
    end else begin
      if (en) model_clear();
    end
  endtask

  function automatic exp_t model_out();
    exp_t e;
    logic [7:0] sym;
    sym = msub ? MINUS : PLUS;
    e.a0 = 4'(ma0); e.a1 = 4'(ma1);
    e.res_mag = 4'(mres_mag); e.res_wrap = 4'(mres_wrap);
    e.pre = mpre;
    e.led = 4'(1 << phase);
    e.eq = (phase == 3) ? EQS : BLANK;
    if (phase == 0) e.op = BLANK;
    else if (phase == 1) e.op = ((op_cycles / BLINK) % 2 == 1) ? BLANK : sym;
    else e.op = sym;
    return e;
  endfunction

  task automatic tick(input bit r, input int s, input bit n, input bit o, input bit c);
    rst = r; sw = 4'(s); btn_next = n; btn_op = o; btn_clr = c;
    model_edge(r, s, n, o, c);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int s, input bit n, input bit o, input bit c);
    tick(0, s, n, o, c);
    tick(0, s, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("mag.a0", {4'd0, m_a0}, {4'd0, e.a0});
      chk("mag.a1", {4'd0, m_a1}, {4'd0, e.a1});
      chk("mag.op", m_op, e.op);
      chk("mag.eq", m_eq, e.eq);
      chk("mag.prefix", m_pre, e.pre);
      chk("mag.result", {4'd0, m_res}, {4'd0, e.res_mag});
      chk("mag.state_led", {4'd0, m_led}, {4'd0, e.led});
      chk("wrap.a0", {4'd0, w_a0}, {4'd0, e.a0});
      chk("wrap.a1", {4'd0, w_a1}, {4'd0, e.a1});
      chk("wrap.op", w_op, e.op);
      chk("wrap.eq", w_eq, e.eq);
      chk("wrap.prefix", w_pre, e.pre);
      chk("wrap.result", {4'd0, w_res}, {4'd0, e.res_wrap});
      chk("wrap.state_led", {4'd0, w_led}, {4'd0, e.led});
    end
  end

  initial begin
    rst = 1'b1; sw = 4'd0; btn_next = 1'b0; btn_op = 1'b0; btn_clr = 1'b0;
    model_clear(); pn = 0; po = 0; pc = 0; op_cycles = 0;

    // Reset with next held, then release: exactly one advance.
    repeat (3) tick(1, 0, 1, 0, 0);
    repeat (4) tick(0, 0, 1, 0, 0);
    tick(0, 0, 0, 0, 0);
    press(0, 0, 0, 1);

    // Add with carry: 9 + 8.
    tick(0, 9, 0, 0, 0);
    press(9, 1, 0, 0);
    press(9, 1, 0, 0);
    tick(0, 8, 0, 0, 0);
    press(8, 1, 0, 0);
    repeat (3) tick(0, 8, 0, 0, 0);
    press(8, 1, 0, 0);

    // Subtract negative 3 - 5, with a blink check and a toggle at cycle 5.
    tick(0, 3, 0, 0, 0);
    press(3, 1, 0, 0);
    repeat (3) tick(0, 3, 0, 0, 0);
    press(3, 0, 1, 0);
    repeat (5) tick(0, 3, 0, 0, 0);
    press(3, 1, 0, 0);
    tick(0, 5, 0, 0, 0);
    press(5, 1, 0, 0);
    press(5, 0, 1, 0);
    press(5, 1, 0, 0);

    // Toggle and advance together in OP; then clr + next together in A1.
    press(6, 1, 0, 0);
    press(6, 1, 1, 0);
    tick(0, 2, 0, 0, 0);
    press(2, 1, 0, 1);
    tick(0, 4, 0, 0, 0);

    // Next held 100 cycles.
    repeat (100) tick(0, 4, 1, 0, 0);
    tick(0, 4, 0, 0, 0);
    press(4, 1, 0, 1);

    // 3 + 4 = 7 in SHOW, then reset mid-operation.
    tick(0, 3, 0, 0, 0);
    press(3, 1, 0, 0);
    press(3, 1, 0, 0);
    tick(0, 4, 0, 0, 0);
    press(4, 1, 0, 0);
    tick(1, 4, 0, 0, 0);
    tick(0, 4, 0, 0, 0);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      tick(($urandom_range(0, 299) == 0), int'($urandom_range(0, 15)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 24) == 0));
    end
    tick(0, 0, 0, 0, 0);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/calc_entry_controller.md
Name: calc_entry_controller

Overview:
- Sequencing controller for the six-digit calculator display path.
- Walks the user through entering A0, choosing the operation (+/-) and entering A1 from the slide switches, then computes and latches the 4-bit result.
- Drives the a0/a1/op/eq/prefix/result inputs of the display block; the display block and its hex decoders stay purely combinational downstream.
- Sits between the board I/O (switches, already-debounced keys) and the display block.

Parameters:
- BLINK_CYCLES, 25000000, half-period in clk cycles of the op-symbol blink in the op-select state (0.5 s at 50 MHz).
- SUB_NEG_MAG, 1, 1: subtraction with A0<A1 shows '-' plus magnitude; 0: shows '-' plus raw 4-bit wrap.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- sw  in  4  operand entry switches
- btn_next  in  1  advance key; level, debounced and synchronised, active-high
- btn_op  in  1  toggle +/- key; level, debounced and synchronised, active-high
- btn_clr  in  1  abort key; level, debounced and synchronised, active-high
- a0  out  4  operand A0 nibble
- a1  out  4  operand A1 nibble
- op  out  8  active-low segment code for the operator digit
- eq  out  8  active-low segment code for the '=' digit
- prefix  out  8  active-low segment code for the carry/sign digit
- result  out  4  result nibble
- state_led  out  4  one-hot state indicator: [0] A0, [1] OP, [2] A1, [3] SHOW

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state changes on the rising edge of clk.
- Key handling:
  - Each key is registered once. A press is the rising edge: level high now, low on the previous cycle.
  - One press causes exactly one action, however long the key is held.
  - The key registers clear to 0 on rst, so a key already held when reset releases counts as a press on the first cycle after release.
- FSM states: S_A0, S_OP, S_A1, S_SHOW.
- Reset values:
  - state S_A0; stored A0, A1 = 0; operator = ADD; result = 0.
  - op = SEG_BLANK, eq = SEG_BLANK, prefix = SEG_BLANK; state_led = 4'b0001.
- S_A0:
  - a0 follows sw live (registered, 1-cycle latency); a1 = 0; op, eq, prefix = SEG_BLANK; result = 0.
  - btn_next press: latch sw into A0, go to S_OP.
- S_OP:
  - op shows SEG_PLUS or SEG_MINUS, blinking. Visible for the first BLINK_CYCLES cycles after entry, blank for the next BLINK_CYCLES, and so on.
  - The blink counter resets to 0 on every entry to S_OP.
  - btn_op press toggles the operator; the blink phase is kept.
  - btn_next press: go to S_A1.
- S_A1:
  - op is shown steady; a1 follows sw live.
  - btn_next press: latch sw into A1, go to S_SHOW.
  - The result is computed in the same edge from the latched values.
- Arithmetic, in 5 bits:
  - ADD: sum = A0 + A1. result = sum[3:0]. prefix = SEG_ONE if sum[4], else SEG_BLANK.
  - SUB with A0 >= A1: result = A0 - A1, prefix = SEG_BLANK.
  - SUB with A0 < A1: prefix = SEG_MINUS. result = A1 - A0 if SUB_NEG_MAG = 1, else (A0 - A1) mod 16.
- S_SHOW:
  - eq = SEG_EQ; all fields steady; result valid from the first cycle in S_SHOW.
  - btn_next press: clear A0, A1, result, operator = ADD, go to S_A0.
  - btn_op is ignored.
- btn_clr press, any state: same clear as S_SHOW exit, go to S_A0.
- Simultaneous presses:
  - btn_clr has priority over btn_next and btn_op.
  - In S_OP, btn_next and btn_op in the same cycle: apply the toggle and advance; the toggled operator is used.
- Idle outputs: no timeouts; the FSM holds in any state indefinitely.
- Mid-operation reset: rst in any state returns to the reset values on the next edge. No partial result survives.

Decomposition:
- Package calc_disp_pkg holds:
  - state enum (S_A0..S_SHOW) and op enum (OP_ADD, OP_SUB);
  - segment constants, active-low, bit order dp,g,f,e,d,c,b,a: SEG_BLANK 8'hFF, SEG_MINUS 8'hBF, SEG_PLUS 8'h8F (e,f,g lit), SEG_EQ 8'hB7, SEG_ONE 8'hF9.
- One sub-module: key_edge (registered rising-edge detector, one instance per key).
- The arithmetic stays inline.

Test Plan:
- Reset then idle: all outputs at reset values, state_led 0001; hold rst with btn_next high, release -> exactly one advance to S_OP.
- Add with carry: sw=9, next; next (ADD); sw=8, next -> a0=9, a1=8, op=8'h8F, eq=8'hB7, prefix=8'hF9, result=1, state_led 1000.
- Sub, negative: sw=3, next; op, next; sw=5, next -> op=8'hBF, prefix=8'hBF, result=2 (SUB_NEG_MAG=1); rerun with SUB_NEG_MAG=0 -> result=4'hE.
- Blink with BLINK_CYCLES=4: in S_OP, op visible for cycles 0-3, SEG_BLANK for 4-7, visible again at 8; a btn_op press at cycle 5 leaves the phase unchanged.
- Priority and held key: btn_clr and btn_next pressed together in S_A1 -> S_A0 with all fields cleared; btn_next held for 100 cycles -> exactly one transition.
- Reset mid-op: rst asserted in S_SHOW with result=7 -> next edge result=0, eq=SEG_BLANK, state_led 0001.
